// File: rtl/bsg_manycore_link_responder_array.sv
// Array of independent request/response links, each answering requests from a small FIFO.
// Optional per-link request counters and seen flags are built when BSG_LINK_RESPONDER_COUNTERS_EN is defined.
module bsg_manycore_link_responder_array #(
  parameter int num_links_p           = 4,
  parameter int packet_width_p        = 64,
  parameter int return_packet_width_p = 42,
  parameter int fifo_els_p            = 2
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic [num_links_p-1:0]                         v_i,
  input  logic [num_links_p*packet_width_p-1:0]          data_i,
  output logic [num_links_p-1:0]                         ready_o,
  output logic [num_links_p-1:0]                         v_o,
  output logic [num_links_p*return_packet_width_p-1:0]   data_o,
  input  logic [num_links_p-1:0]                         ready_i,
  output logic [num_links_p*32-1:0]                      req_count_o,
  output logic [num_links_p-1:0]                         seen_o
);

  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int pw    = packet_width_p;
  localparam int rw    = return_packet_width_p;

  // Only the low 10 bits of each request carry meaning.
  logic unused_data;
  assign unused_data = ^data_i;

  // Holds ready low during reset and releases it on the first edge afterwards.
  logic up_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) up_q <= 1'b0;
    else         up_q <= 1'b1;
  end

  for (genvar k = 0; k < num_links_p; k++) begin : gen_link
    logic [pw-1:0]    req;
    logic [rw-1:0]    resp;
    logic [rw-1:0]    mem_q [fifo_els_p];
    logic [ptr_w-1:0] rptr_q, wptr_q;
    logic [ptr_w:0]   cnt_q, cnt_d;
    logic             enq, deq;

    assign req = data_i[k*pw +: pw];

    always_comb begin
      resp      = '0;
      resp[9:2] = req[9:2];
      if (req[1:0] == 2'd0) begin
        resp[1:0]   = 2'd1;
        resp[41:10] = 32'hDEAD_BEEF;
      end
    end

    assign ready_o[k] = up_q & (cnt_q != (ptr_w+1)'(fifo_els_p));
    assign v_o[k]     = (cnt_q != '0);
    assign enq        = v_i[k] & ready_o[k];
    assign deq        = v_o[k] & ready_i[k];

    always_comb begin
      cnt_d = cnt_q;
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + (ptr_w+1)'(1);
        2'b01:   cnt_d = cnt_q - (ptr_w+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (enq) wptr_q <= wptr_q + ptr_w'(1);
        if (deq) rptr_q <= rptr_q + ptr_w'(1);
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q] <= resp;
    end

    assign data_o[k*rw +: rw] = mem_q[rptr_q];

`ifdef BSG_LINK_RESPONDER_COUNTERS_EN
    logic [31:0] count_q;
    logic        seen_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        count_q <= '0;
        seen_q  <= 1'b0;
      end else if (enq) begin
        if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
        seen_q <= 1'b1;
      end
    end

    assign req_count_o[k*32 +: 32] = count_q;
    assign seen_o[k]               = seen_q;
`else
    assign req_count_o[k*32 +: 32] = '0;
    assign seen_o[k]               = 1'b0;
`endif
  end

endmodule

// File: doc/bsg_manycore_link_responder_array.md
BSG_MANYCORE_LINK_RESPONDER_ARRAY -- requirements
Module: bsg_manycore_link_responder_array

Interface
REQ-001 SHALL have parameter num_links_p, default 4, number of independent link channels (1..32).
REQ-002 SHALL have parameter packet_width_p, default 64, request packet width in bits (minimum 10).
REQ-003 SHALL have parameter return_packet_width_p, default 42, response packet width (fixed layout, minimum 42).
REQ-004 SHALL have parameter fifo_els_p, default 2, response FIFO depth per link (minimum 2, power of two).
REQ-005 SHALL have ports: clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: reset_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: v_i  input  num_links_p  request valid; data_i  input  num_links_p*packet_width_p  request packets (link k at slice k); ready_o  output  num_links_p  request ready.
REQ-008 SHALL have ports: v_o  output  num_links_p  response valid; data_o  output  num_links_p*return_packet_width_p  response packets; ready_i  input  num_links_p  response ready.
REQ-009 SHALL have ports: req_count_o  output  num_links_p*32  per-link accepted-request count; seen_o  output  num_links_p  sticky "request ever accepted" flag.

Function
REQ-010 SHALL treat each link independently; no cross-link arbitration or ordering.
REQ-011 SHALL accept a request on link k when v_i[k] & ready_o[k] at a rising edge.
REQ-012 SHALL drive ready_o[k] = 1 iff link k FIFO holds fewer than fifo_els_p entries, from registered state only (no combinational path from ready_i).
REQ-013 SHALL decode request bits [1:0] as op (0 load, 1 store, 2/3 other) and bits [9:2] as reg_id.
REQ-014 SHALL enqueue one response per accepted request: [1:0]=1 for load else 0; [9:2]=reg_id; [41:10]=32'hDEAD_BEEF for load else 0; bits above 41 zero.
REQ-015 SHALL present an enqueued response on v_o/data_o no earlier than the cycle after acceptance (1-cycle minimum latency, no bypass).
REQ-016 SHALL dequeue the head entry when v_o[k] & ready_i[k]; data_o[k] SHALL be stable while v_o[k]=1 and ready_i[k]=0.
REQ-017 SHALL deliver responses in per-link acceptance order.
REQ-018 Full FIFO: ready_o[k]=0 even if a dequeue occurs that cycle; ready_o[k] SHALL return to 1 the cycle after the dequeue.
REQ-019 Empty FIFO: v_o[k]=0; data_o[k] contents are don't-care.
REQ-020 Simultaneous enqueue and dequeue on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-021 SHALL increment req_count_o[k] by 1 per accepted request, saturating at 32'hFFFF_FFFF (no wrap).
REQ-022 SHALL set seen_o[k] on the first acceptance and hold it until reset.
REQ-023 FIFO read/write pointers SHALL wrap modulo fifo_els_p.

Reset
REQ-024 Assertion of reset_i SHALL immediately, without a clock edge, empty all FIFOs and clear all counters and flags.
REQ-025 While reset_i=1: ready_o=0, v_o=0, req_count_o=0, seen_o=0.
REQ-026 Reset mid-transfer SHALL discard all pending responses; none SHALL appear after deassertion.
REQ-027 ready_o SHALL rise on the first rising edge after reset_i deasserts.

Configuration
REQ-028 SHALL honour macro BSG_LINK_RESPONDER_COUNTERS_EN.
REQ-029 With BSG_LINK_RESPONDER_COUNTERS_EN defined: req_count_o and seen_o behave per REQ-021/REQ-022.
REQ-030 Without it: counter and flag registers SHALL not be instantiated; req_count_o and seen_o SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-031 Single load on link 0, op=0, reg_id=8'h15, ready_i=1 -> v_o[0] one cycle later with data_o[0][41:0] = {32'hDEAD_BEEF, 8'h15, 2'b01}; req_count_o[0]=1, seen_o[0]=1.
REQ-032 Three stores on link 2, ready_i[2]=0, fifo_els_p=2 -> two accepted, ready_o[2]=0 on third; after one dequeue ready_o[2]=1 next cycle, third accepted; responses in order with [1:0]=0, [41:10]=0.
REQ-033 All links loaded concurrently with distinct reg_ids, random ready_i backpressure -> per-link order and payloads preserved, no cross-link leakage.
REQ-034 Two entries queued on link 1, reset_i pulsed mid-cycle between edges -> v_o, counts, seen_o go 0 at once; no stale response after release.
REQ-035 Counter forced to 32'hFFFF_FFFE, three requests accepted -> req_count_o holds 32'hFFFF_FFFF.
REQ-036 Build without BSG_LINK_RESPONDER_COUNTERS_EN, run REQ-031 -> identical response, req_count_o=0, seen_o=0.
